// File: rtl/dbg_trace_tx_if.sv
// Byte stream carrying serialized trace frames from the transmitter to a UART or debug link.
interface dbg_trace_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/dbg_trace_tx.sv
// Execute-stage trace capture: records buffered in a small FIFO and sent as framed bytes;
// a sticky halt request follows a traced WFI once everything has drained.
//   state | meaning
//   IDLE  | no frame in flight; start one when the FIFO holds a record
//   HDR   | sending sync byte 0xA5
//   FLG   | sending {wfi, trap, bj, rd}
//   PC    | sending pc, byte idx 0..7
//   RES   | sending result, byte idx 0..7
//   TGT   | sending target, byte idx 0..7 (only for trap/bj records)
module dbg_trace_tx #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trace_en,
  input  logic                 stall,
  input  logic [63:0]          pc,
  input  logic [4:0]           rd,
  input  logic [63:0]          result,
  input  logic                 bj_en,
  input  logic [63:0]          bj_pc,
  input  logic                 trap_en,
  input  logic [63:0]          trap_pc,
  input  logic                 wfi_op,
  dbg_trace_tx_if.master       tx,
  output logic                 halt,
  output logic [15:0]          drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FLG, S_PC, S_RES, S_TGT
  } state_t;

  state_t         state, state_nx;
  logic [2:0]     idx, idx_nx;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           halt_pending;

  logic [63:0]    pc_mem  [DEPTH];
  logic [63:0]    res_mem [DEPTH];
  logic [63:0]    tgt_mem [DEPTH];
  logic [7:0]     flg_mem [DEPTH];

  logic           capture, full, push, drop, pop, accept, valid_q;
  logic [7:0]     data_q;
  logic [7:0]     head_flg;

  // Fullness is judged on the pre-edge count, so a same-cycle pop cannot rescue a capture.
  assign capture  = trace_en & ~stall;
  assign full     = (count == CW'(DEPTH));
  assign push     = capture & ~full;
  assign drop     = capture & full;
  assign head_flg = flg_mem[rd_ptr];
  assign valid_q  = (state != S_IDLE);
  assign accept   = valid_q & tx.tx_ready;

  assign tx.tx_valid = valid_q;
  assign tx.tx_data  = data_q;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= pc;
      res_mem[wr_ptr] <= result;
      tgt_mem[wr_ptr] <= trap_en ? trap_pc : (bj_en ? bj_pc : 64'd0);
      flg_mem[wr_ptr] <= {wfi_op, trap_en, bj_en, rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      state        <= S_IDLE;
      idx          <= '0;
      drop_cnt     <= '0;
      halt_pending <= 1'b0;
      halt         <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      if (capture && wfi_op) halt_pending <= 1'b1;
      if (halt_pending && count == '0 && state == S_IDLE) halt <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    pop      = 1'b0;
    data_q   = 8'h00;
    case (state)
      S_IDLE: begin
        idx_nx = '0;
        if (count != '0) state_nx = S_HDR;
      end
      S_HDR: begin
        data_q = 8'hA5;
        if (accept) state_nx = S_FLG;
      end
      S_FLG: begin
        data_q = head_flg;
        if (accept) begin
          state_nx = S_PC;
          idx_nx   = '0;
        end
      end
      S_PC: begin
        data_q = pc_mem[rd_ptr][{idx, 3'b000} +: 8];
        if (accept) begin
          idx_nx = idx + 1'b1;
          if (idx == 3'd7) state_nx = S_RES;
        end
      end
      S_RES: begin
        data_q = res_mem[rd_ptr][{idx, 3'b000} +: 8];
        if (accept) begin
          idx_nx = idx + 1'b1;
          if (idx == 3'd7) begin
            if (head_flg[6] | head_flg[5]) begin
              state_nx = S_TGT;
            end else begin
              state_nx = S_IDLE;
              pop      = 1'b1;
            end
          end
        end
      end
      S_TGT: begin
        data_q = tgt_mem[rd_ptr][{idx, 3'b000} +: 8];
        if (accept) begin
          idx_nx = idx + 1'b1;
          if (idx == 3'd7) begin
            state_nx = S_IDLE;
            pop      = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
